quadrature_encoder_gen: RTL and testbench
=========================================

# quadrature_encoder_gen

Synthesises A/B/I quadrature encoder waveforms from commanded step moves, for closed-loop bench testing of the encoder input path and motor-free motion firmware bring-up. A command accepted on a valid/ready handshake gives a signed edge count and an edge period in clocks. The block emits exactly that many X4 edges at a fixed rate, with A leading B for positive moves. It sits between the register bank and the encoder input pins and is selected in place of the physical encoder by a test mux.

## Interface
- PERIOD_W, 16: width of cmd_period
- STEPS_W, 16: width of cmd_steps (signed)
- POS_W, 32: width of position (signed)
- COUNTS_PER_REV, 400: X4 edges per revolution; must be a multiple of 4 and at least 4
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_steps  in  STEPS_W  signed edge count; positive = forward
- cmd_period  in  PERIOD_W  clocks per edge; 0 is treated as 1
- abort  in  1  terminate the current move
- quadA  out  1  encoder channel A (registered)
- quadB  out  1  encoder channel B (registered)
- quadI  out  1  index (registered)
- busy  out  1  move in progress
- done  out  1  one-cycle pulse on normal move completion
- position  out  POS_W  signed running edge count

## Operation
- States are IDLE and RUN.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid: latch dir = sign(cmd_steps), remaining = |cmd_steps| and P = max(cmd_period,1), then load timer = P-1.
  - If cmd_steps != 0, go to RUN.
  - If cmd_steps = 0, stay in IDLE and pulse done on the next cycle. No edges are produced.
- **RUN**
  - cmd_ready=0 and busy=1.
  - Each clock: if timer = 0, take one step and reload timer = P-1; otherwise decrement timer.
- **Step**
  - rev_pos moves +1 (forward) or -1 (reverse), modulo COUNTS_PER_REV.
  - position changes by ±1 and wraps two's-complement.
  - remaining is decremented.
  - When remaining reaches 0, return to IDLE and pulse done in the cycle after the last edge.
- **Phase map** (rev_pos[1:0] to AB): 0 = 00, 1 = 10, 2 = 11, 3 = 01.
  - Forward sequence is 00→10→11→01→00, which a downstream X4 decoder reads as direction=1.
- **Index**
  - quadI is set on a step whose new rev_pos = 0 and cleared on the next step.
  - It is never asserted directly from reset; only reaching rev_pos = 0 by a step sets it.
- **abort**
  - abort in RUN returns to IDLE on the next clock with no done pulse.
  - quadA, quadB, quadI, position and rev_pos hold their current values.
  - abort in IDLE has no effect.
  - If abort coincides with a step in the same cycle, the step still completes and abort then takes effect.
- cmd_valid while in RUN is ignored, because cmd_ready=0.
- **reset**
  - Reset forces IDLE, whether or not a move is in progress.
  - Reset values: quadA=0, quadB=0, quadI=0, busy=0, done=0, position=0, rev_pos=0, cmd_ready=1.

## Timing
- A command accepted at clock edge N produces its first output change after edge N+P, and subsequent edges every P clocks.
- With P=1, an edge is produced on every clock.
- The final edge of the move occurs after edge N+k·P, where k = |cmd_steps|.
  - done is high for the cycle after edge N+k·P+1.
  - busy falls in that same cycle, and cmd_ready is high again in it.
- A new command may be accepted in the same cycle that done is high.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package (global_constants / encoder package):
  - state enum {IDLE, RUN}
  - AB phase lookup constant for rev_pos[1:0]
  - default COUNTS_PER_REV
- Sub-module quadrature_step_timer:
  - Reload down-counter that produces the one-cycle step strobe.
  - Inputs: load, period, run.
  - Output: step.
- Top level: handshake, FSM, rev_pos/position counters, and output registers.

## Test plan
- Reset, then cmd_steps=+8, cmd_period=4, COUNTS_PER_REV=8 → 8 edges 4 clocks apart with AB sequence 10,11,01,00,10,11,01,00; quadI high after the 8th edge; position=8; single done pulse.
- cmd_steps=-5, cmd_period=0 → one edge per clock; AB sequence 01,11,10,00,01; position=-5; no index; decoder reports direction=0 on every edge.
- cmd_steps=0 → no AB change; done pulse one cycle after acceptance; busy stays 0.
- cmd_steps=+100, cmd_period=10, abort asserted after 37 edges → AB holds its level; position=37; no done pulse; cmd_ready=1 the next cycle.
- Mid-move reset (steps=+20, reset asserted after 6 edges) → all outputs return to their reset values asynchronously; the next command starts from AB=00 and position=0.
- Back-to-back: second command driven with cmd_valid held during the first move → the second command is accepted in the done cycle and its first edge follows P2 clocks later; position is the sum of both moves.

Source files
------------

// File: rtl/quadrature_encoder_gen_pkg.sv
// rtl/quadrature_encoder_gen_pkg.sv - shared constants for the quadrature encoder generator
package quadrature_encoder_gen_pkg;

    localparam int DEFAULT_COUNTS_PER_REV = 400;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        STATE_IDLE = 1'b0,
        STATE_RUN  = 1'b1
    } qe_state_e;

    // {A,B} for rev_pos[1:0] = 3,2,1,0 from MSB down: 01, 11, 10, 00
    localparam logic [7:0] AB_PHASE_MAP = 8'b01_11_10_00;

    function automatic logic [1:0] ab_phase(input logic [1:0] phase);
        return AB_PHASE_MAP[{phase, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/quadrature_step_timer.sv
// rtl/quadrature_step_timer.sv - reload down-counter producing the per-edge step strobe
module quadrature_step_timer
    import quadrature_encoder_gen_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period,
    input  logic                run,
    output logic                step
);

    logic [PERIOD_W-1:0] r_reload;
    logic [PERIOD_W-1:0] r_timer;
    logic [PERIOD_W-1:0] w_period_m1;

    // A period of zero behaves as one clock per edge
    assign w_period_m1 = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign step        = run && (r_timer == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reload <= '0;
            r_timer  <= '0;
        end else if (load) begin
            r_reload <= w_period_m1;
            r_timer  <= w_period_m1;
        end else if (run) begin
            r_timer <= (r_timer == '0) ? r_reload : r_timer - PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/quadrature_encoder_gen.sv
// rtl/quadrature_encoder_gen.sv - A/B/I quadrature waveform synthesiser driven by step-move commands
module quadrature_encoder_gen
    import quadrature_encoder_gen_pkg::*;
#(
    parameter int PERIOD_W       = 16,
    parameter int STEPS_W        = 16,
    parameter int POS_W          = 32,
    parameter int COUNTS_PER_REV = DEFAULT_COUNTS_PER_REV
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [STEPS_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    output logic                quadA,
    output logic                quadB,
    output logic                quadI,
    output logic                busy,
    output logic                done,
    output logic [POS_W-1:0]    position
);

    localparam int REV_W = (COUNTS_PER_REV > 4) ? $clog2(COUNTS_PER_REV) : 2;
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(COUNTS_PER_REV - 1);

    logic [0:0]         r_state;
    logic               r_dir;
    logic [STEPS_W-1:0] r_remaining;
    logic [REV_W-1:0]   r_rev_pos;
    logic [POS_W-1:0]   r_position;
    logic               r_quad_a;
    logic               r_quad_b;
    logic               r_quad_i;
    logic               r_done;

    logic               w_accept;
    logic               w_run;
    logic               w_step;
    logic               w_steps_neg;
    logic [STEPS_W-1:0] w_steps_mag;
    logic [REV_W-1:0]   w_rev_next;
    logic [POS_W-1:0]   w_pos_next;
    logic [1:0]         w_ab_next;

    assign w_accept    = (r_state == ST_IDLE) && cmd_valid;
    assign w_run       = (r_state == ST_RUN);
    assign w_steps_neg = cmd_steps[STEPS_W-1];
    // Magnitude fits unsigned in STEPS_W bits, including the most negative count
    assign w_steps_mag = w_steps_neg ? (~cmd_steps + STEPS_W'(1)) : cmd_steps;

    always_comb begin
        w_rev_next = r_rev_pos;
        if (r_dir) begin
            w_rev_next = (r_rev_pos == REV_MAX) ? '0 : r_rev_pos + REV_W'(1);
        end else begin
            w_rev_next = (r_rev_pos == '0) ? REV_MAX : r_rev_pos - REV_W'(1);
        end
    end

    assign w_pos_next = r_dir ? r_position + POS_W'(1) : r_position - POS_W'(1);
    assign w_ab_next  = ab_phase(w_rev_next[1:0]);

    quadrature_step_timer #(
        .PERIOD_W(PERIOD_W)
    ) u_step_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (w_accept),
        .period (cmd_period),
        .run    (w_run),
        .step   (w_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_dir       <= 1'b1;
            r_remaining <= '0;
            r_rev_pos   <= '0;
            r_position  <= '0;
            r_quad_a    <= 1'b0;
            r_quad_b    <= 1'b0;
            r_quad_i    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_dir       <= !w_steps_neg;
                        r_remaining <= w_steps_mag;
                        if (w_steps_mag == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Finishing takes one extra cycle after the last edge
                    if (r_remaining == '0) begin
                        r_state <= ST_IDLE;
                        r_done  <= !abort;
                    end else begin
                        if (w_step) begin
                            r_rev_pos   <= w_rev_next;
                            r_position  <= w_pos_next;
                            r_quad_a    <= w_ab_next[1];
                            r_quad_b    <= w_ab_next[0];
                            r_quad_i    <= (w_rev_next == '0);
                            r_remaining <= r_remaining - STEPS_W'(1);
                        end
                        if (abort) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN);
    assign done      = r_done;
    assign quadA     = r_quad_a;
    assign quadB     = r_quad_b;
    assign quadI     = r_quad_i;
    assign position  = r_position;

endmodule

// File: tb/tb_quadrature_encoder_gen.sv
// tb/tb_quadrature_encoder_gen.sv - directed self-checking bench for quadrature_encoder_gen
module tb_quadrature_encoder_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_steps = '0;
    logic [15:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        quadA;
    logic        quadB;
    logic        quadI;
    logic        busy;
    logic        done;
    logic [31:0] position;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    quadrature_encoder_gen #(
        .PERIOD_W(16),
        .STEPS_W(16),
        .POS_W(32),
        .COUNTS_PER_REV(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .quadA      (quadA),
        .quadB      (quadB),
        .quadI      (quadI),
        .busy       (busy),
        .done       (done),
        .position   (position)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cmd_valid = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic issue_cmd(input logic [15:0] steps, input logic [15:0] period);
        cmd_steps = steps;
        cmd_period = period;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Downstream X4 decoder view: 1 when new AB is the forward successor of prev AB
    function automatic logic decode_dir(input logic [1:0] prev, input logic [1:0] cur);
        case (prev)
            2'b00:   return cur == 2'b10;
            2'b10:   return cur == 2'b11;
            2'b11:   return cur == 2'b01;
            default: return cur == 2'b00;
        endcase
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if ({quadA, quadB, quadI} !== 3'b000) begin failures++; $display("FAIL reset_abi: got %b expected 000", {quadA, quadB, quadI}); end
        checks++; if ({busy, done, cmd_ready} !== 3'b001) begin failures++; $display("FAIL reset_ctl: got %b expected 001", {busy, done, cmd_ready}); end
        checks++; if (position !== 32'd0) begin failures++; $display("FAIL reset_pos: got %0d expected 0", position); end
    endtask

    task automatic test_forward();
        logic [1:0] exp_ab [8];
        logic [1:0] prev;
        exp_ab = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        do_reset();
        issue_cmd(16'd8, 16'd4);
        prev = 2'b00;
        for (int j = 0; j < 8; j++) begin
            for (int c = 1; c <= 4; c++) begin
                tick();
                checks++;
                if (c < 4) begin
                    if ({quadA, quadB} !== prev) begin failures++; $display("FAIL fwd_hold e%0d c%0d: got %b expected %b", j, c, {quadA, quadB}, prev); end
                end else begin
                    if ({quadA, quadB} !== exp_ab[j]) begin failures++; $display("FAIL fwd_edge e%0d: got %b expected %b", j, {quadA, quadB}, exp_ab[j]); end
                    checks++; if (quadI !== (j == 7)) begin failures++; $display("FAIL fwd_index e%0d: got %b expected %b", j, quadI, (j == 7)); end
                    checks++; if ((busy !== 1'b1) || (done !== 1'b0)) begin failures++; $display("FAIL fwd_busy e%0d: got busy=%b done=%b expected 1 0", j, busy, done); end
                    prev = exp_ab[j];
                end
            end
        end
        tick();
        checks++; if ({done, busy, cmd_ready} !== 3'b101) begin failures++; $display("FAIL fwd_done: got %b expected 101", {done, busy, cmd_ready}); end
        checks++; if (position !== 32'd8) begin failures++; $display("FAIL fwd_pos: got %0d expected 8", position); end
        tick();
        checks++; if ((done !== 1'b0) || (quadI !== 1'b1)) begin failures++; $display("FAIL fwd_after: got done=%b quadI=%b expected 0 1", done, quadI); end
    endtask

    task automatic test_reverse();
        logic [1:0] exp_ab [5];
        logic [1:0] prev;
        exp_ab = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        do_reset();
        issue_cmd(16'hFFFB, 16'd0);
        prev = 2'b00;
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++; if ({quadA, quadB} !== exp_ab[j]) begin failures++; $display("FAIL rev_edge e%0d: got %b expected %b", j, {quadA, quadB}, exp_ab[j]); end
            checks++; if (decode_dir(prev, {quadA, quadB}) !== 1'b0) begin failures++; $display("FAIL rev_dir e%0d: got 1 expected 0", j); end
            checks++; if (quadI !== 1'b0) begin failures++; $display("FAIL rev_index e%0d: got %b expected 0", j, quadI); end
            prev = {quadA, quadB};
        end
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL rev_done: got %b expected 1", done); end
        checks++; if (position !== 32'hFFFF_FFFB) begin failures++; $display("FAIL rev_pos: got %0h expected fffffffb", position); end
    endtask

    task automatic test_zero();
        do_reset();
        abort = 1'b1;
        issue_cmd(16'd0, 16'd3);
        abort = 1'b0;
        checks++; if ({done, busy, cmd_ready} !== 3'b101) begin failures++; $display("FAIL zero_done: got %b expected 101", {done, busy, cmd_ready}); end
        tick();
        checks++; if ({done, busy} !== 2'b00) begin failures++; $display("FAIL zero_after: got %b expected 00", {done, busy}); end
        checks++; if ({quadA, quadB, position} !== 34'd0) begin failures++; $display("FAIL zero_ab: got %b/%0d expected 00/0", {quadA, quadB}, position); end
    endtask

    task automatic test_abort();
        logic saw_done;
        do_reset();
        issue_cmd(16'd100, 16'd10);
        repeat (370) tick();
        checks++; if (position !== 32'd37) begin failures++; $display("FAIL abort_pre: got %0d expected 37", position); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if ({cmd_ready, busy, done} !== 3'b100) begin failures++; $display("FAIL abort_state: got %b expected 100", {cmd_ready, busy, done}); end
        saw_done = 1'b0;
        repeat (20) begin
            tick();
            saw_done = saw_done | done;
        end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_nodone: got 1 expected 0"); end
        checks++; if ({quadA, quadB, quadI} !== 3'b100) begin failures++; $display("FAIL abort_hold: got %b expected 100", {quadA, quadB, quadI}); end
        checks++; if (position !== 32'd37) begin failures++; $display("FAIL abort_pos: got %0d expected 37", position); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        issue_cmd(16'd20, 16'd2);
        repeat (12) tick();
        checks++; if (position !== 32'd6) begin failures++; $display("FAIL mrst_pre: got %0d expected 6", position); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({quadA, quadB, quadI, busy, done, cmd_ready} !== 6'b000001) begin failures++; $display("FAIL mrst_async: got %b expected 000001", {quadA, quadB, quadI, busy, done, cmd_ready}); end
        checks++; if (position !== 32'd0) begin failures++; $display("FAIL mrst_pos: got %0d expected 0", position); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        issue_cmd(16'd3, 16'd1);
        tick();
        checks++; if ({quadA, quadB} !== 2'b10) begin failures++; $display("FAIL mrst_first: got %b expected 10", {quadA, quadB}); end
        repeat (2) tick();
        checks++; if (({quadA, quadB} !== 2'b01) || (position !== 32'd3)) begin failures++; $display("FAIL mrst_end: got %b/%0d expected 01/3", {quadA, quadB}, position); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cmd_steps = 16'd3;
        cmd_period = 16'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_steps = 16'hFFFE;
        cmd_period = 16'd3;
        repeat (6) tick();
        checks++; if ({busy, done, position} !== {2'b10, 32'd3}) begin failures++; $display("FAIL b2b_first: got busy=%b done=%b pos=%0d expected 1 0 3", busy, done, position); end
        tick();
        checks++; if ({done, cmd_ready} !== 2'b11) begin failures++; $display("FAIL b2b_done: got %b expected 11", {done, cmd_ready}); end
        tick();
        cmd_valid = 1'b0;
        checks++; if ({busy, done} !== 2'b10) begin failures++; $display("FAIL b2b_accept: got %b expected 10", {busy, done}); end
        repeat (2) tick();
        checks++; if (position !== 32'd3) begin failures++; $display("FAIL b2b_wait: got %0d expected 3", position); end
        tick();
        checks++; if (({quadA, quadB} !== 2'b11) || (position !== 32'd2)) begin failures++; $display("FAIL b2b_edge1: got %b/%0d expected 11/2", {quadA, quadB}, position); end
        repeat (3) tick();
        checks++; if (({quadA, quadB} !== 2'b10) || (position !== 32'd1)) begin failures++; $display("FAIL b2b_edge2: got %b/%0d expected 10/1", {quadA, quadB}, position); end
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done2: got %b expected 1", done); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_zero();
        test_abort();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
